// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter between the core and the host loader.
package dmem_arb_pkg;

  localparam int DATA_W_DEF        = 8;
  localparam int ADDR_W_DEF        = 8;
  localparam int MEM_RD_LAT_DEF    = 1;
  localparam int HOST_MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_HOST = 2'b10
  } owner_t;

endpackage

// File: rtl/dmem_grant_sel.sv
// Combinational winner pick: core first, host when the core is halted or the host has waited too long.
module dmem_grant_sel (
  input  logic core_req,
  input  logic host_req,
  input  logic core_halted,
  input  logic starve_full,
  output logic grant_core,
  output logic grant_host
);

  logic host_pri;

  always_comb begin
    host_pri   = core_halted | starve_full;
    grant_host = host_req & (~core_req | host_pri);
    grant_core = core_req & ~grant_host;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: one access at a time, registered memory strobes, one-cycle ack per access.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int MEM_RD_LAT    = MEM_RD_LAT_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              core_halted,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam int SC_W  = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;

  arb_state_t        state;
  owner_t            owner_q;
  logic [CNT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              starve_full;
  logic              grant_core;
  logic              grant_host;

  assign starve_full = (starve_cnt == SC_W'(HOST_MAX_WAIT));
  assign owner       = owner_q;

  dmem_grant_sel u_grant_sel (
    .core_req    (core_req),
    .host_req    (host_req),
    .core_halted (core_halted),
    .starve_full (starve_full),
    .grant_core  (grant_core),
    .grant_host  (grant_host)
  );

  // Handshake: a requester raises req with we/addr/wdata stable and holds it until its
  // one-cycle ack; it drops req at the edge ending the ack cycle. Requests are only
  // sampled in IDLE, and the access fields are latched at the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_q    <= OWN_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= 1'b0;
      host_ack   <= 1'b0;
      core_rdata <= '0;
      host_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_host) begin
            state      <= ISSUE;
            mem_en     <= 1'b1;
            mem_we     <= host_we;
            mem_addr   <= host_addr;
            mem_wdata  <= host_wdata;
            owner_q    <= OWN_HOST;
            starve_cnt <= '0;
          end else if (grant_core) begin
            state     <= ISSUE;
            mem_en    <= 1'b1;
            mem_we    <= core_we;
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
            owner_q   <= OWN_CORE;
            if (host_req && !starve_full) starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        ISSUE: begin
          // mem_we still carries the latched direction during this single strobe cycle.
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            state    <= DONE;
            core_ack <= (owner_q == OWN_CORE);
            host_ack <= (owner_q == OWN_HOST);
          end else begin
            state   <= WAIT_RD;
            lat_cnt <= CNT_W'(MEM_RD_LAT - 1);
          end
        end
        WAIT_RD: begin
          if (lat_cnt == '0) begin
            state <= DONE;
            if (owner_q == OWN_CORE) begin
              core_rdata <= mem_rdata;
              core_ack   <= 1'b1;
            end
            if (owner_q == OWN_HOST) begin
              host_rdata <= mem_rdata;
              host_ack   <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          owner_q  <= OWN_NONE;
          core_ack <= 1'b0;
          host_ack <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          owner_q    <= OWN_NONE;
          lat_cnt    <= '0;
          starve_cnt <= '0;
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          core_ack   <= 1'b0;
          host_ack   <= 1'b0;
          core_rdata <= '0;
          host_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, per-access latency/strobe checks and a grant-order scoreboard.
module tb_dmem_arbiter;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int LAT  = 1;
  localparam int MAXW = 4;

  logic          clk;
  logic          rst_n;
  logic          core_req, core_we, core_ack, core_halted;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    owner;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .MEM_RD_LAT    (LAT),
    .HOST_MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_ack    (core_ack),
    .core_halted (core_halted),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .owner       (owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: loads a fixed pattern while mem_load is high, read latency of one cycle.
  logic [DW-1:0] mem [256];
  logic          mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[8'h20] <= 8'h3C;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Grant log for the scoreboard
  logic       log_en;
  logic [1:0] grant_log[$];
  logic [1:0] exp_q[$];
  int         core_acks = 0;
  int         host_acks = 0;

  always @(negedge clk) begin
    if (mem_en && log_en) grant_log.push_back(owner);
    if (core_ack) core_acks++;
    if (host_ack) host_acks++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic access(input bit host, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                        input string tag);
    int exp_cyc = we ? 2 : 2 + LAT;
    int cyc     = 0;
    bit seen    = 0;
    @(posedge clk); #1;
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    @(posedge clk);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, ".en"},    32'({mem_en, mem_we}), 32'({1'b1, we}));
        check({tag, ".addr"},  32'(mem_addr), 32'(addr));
        check({tag, ".owner"}, 32'(owner), host ? 32'(2) : 32'(1));
        if (we) check({tag, ".wdata"}, 32'(mem_wdata), 32'(wdata));
      end
      if (c == 2) check({tag, ".en_pulse"}, 32'(mem_en), 32'(0));
      check({tag, ".other_ack"}, 32'(host ? core_ack : host_ack), 32'(0));
      if (host ? host_ack : core_ack) begin
        seen = 1;
        cyc  = c;
      end
    end
    check({tag, ".lat"}, 32'(cyc), 32'(exp_cyc));
    if (seen) begin
      check({tag, ".done_en"},    32'(mem_en), 32'(0));
      check({tag, ".done_owner"}, 32'(owner), host ? 32'(2) : 32'(1));
      if (!we) check({tag, ".rdata"}, 32'(host ? host_rdata : core_rdata), 32'(exp_rd));
    end
    @(posedge clk); #1;
    if (host) host_req = 1'b0;
    else      core_req = 1'b0;
    @(negedge clk);
    check({tag, ".idle_owner"}, 32'(owner), 32'(0));
    check({tag, ".idle_ack"},   32'({core_ack, host_ack}), 32'(0));
  endtask

  task automatic wait_ack(input bit host, input string tag, input bit chk_rd,
                          input logic [DW-1:0] exp_rd);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (host ? host_ack : core_ack) seen = 1;
    end
    check({tag, ".ack"}, 32'(seen), 32'(1));
    if (chk_rd) check({tag, ".rdata"}, 32'(host ? host_rdata : core_rdata), 32'(exp_rd));
    @(posedge clk); #1;
    if (host) host_req = 1'b0;
    else      core_req = 1'b0;
  endtask

  // stimulus
  bit got;
  int n_ack;
  int acks0;
  logic [1:0] e_own, g_own;

  initial begin
    rst_n = 1'b0; mem_load = 1'b1; log_en = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_halted = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.mem_en",   32'({mem_en, mem_we}), 32'(0));
    check("rst.mem_addr", 32'(mem_addr), 32'(0));
    check("rst.mem_wdat", 32'(mem_wdata), 32'(0));
    check("rst.acks",     32'({core_ack, host_ack}), 32'(0));
    check("rst.rdata",    32'({core_rdata, host_rdata}), 32'(0));
    check("rst.owner",    32'(owner), 32'(0));
    rst_n = 1'b1; mem_load = 1'b0;

    access(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, "core_wr");
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, "host_rd");
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, "core_rd");
    check("hold.host_rdata", 32'(host_rdata), 32'(8'h3C));

    // Contention: both held continuously; expected order C C C C H C C C C H
    grant_log.delete();
    log_en = 1'b1;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h41; host_wdata = 8'h22;
    n_ack = 0;
    for (int c = 0; c < 200 && n_ack < 10; c++) begin
      @(negedge clk);
      if (core_ack || host_ack) n_ack++;
    end
    @(posedge clk); #1;
    core_req = 1'b0; host_req = 1'b0;
    log_en = 1'b0;
    check("cont.acks", 32'(n_ack), 32'(10));
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
    end
    check("cont.grants", 32'(grant_log.size()), 32'(10));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e_own = exp_q.pop_front();
      g_own = (grant_log.size() > 0) ? grant_log.pop_front() : 2'b11;
      check($sformatf("cont.order%0d", k), 32'(g_own), 32'(e_own));
    end

    // Halted core: host wins first even though both request together
    core_halted = 1'b1;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h50; host_wdata = 8'h77;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mem_en) got = 1'b1;
    end
    check("halt.grant_seen", 32'(got), 32'(1));
    check("halt.first_owner", 32'(owner), 32'(2));
    wait_ack(1'b1, "halt.host", 1'b0, 8'h00);
    wait_ack(1'b0, "halt.core", 1'b1, 8'hA5);
    core_halted = 1'b0;
    check("halt.host_rdata_hold", 32'(host_rdata), 32'(8'h3C));
    access(1'b1, 1'b0, 8'h50, 8'h00, 8'h77, "host_rd50");

    // Reset during WAIT_RD abandons the access
    acks0 = core_acks;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h33;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rstmid.owner_before", 32'(owner), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'(0));
    check("rstmid.acks", 32'({core_ack, host_ack}), 32'(0));
    check("rstmid.rdata", 32'({core_rdata, host_rdata}), 32'(0));
    check("rstmid.owner", 32'(owner), 32'(0));
    core_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid.no_ack", 32'(core_acks - acks0), 32'(0));
    access(1'b0, 1'b0, 8'h33, 8'h00, 8'h69, "rstmid.after");

    // Back-to-back core requests: one ack each
    acks0 = core_acks;
    access(1'b0, 1'b1, 8'h60, 8'h5B, 8'h00, "b2b.wr0");
    access(1'b0, 1'b1, 8'h61, 8'hC3, 8'h00, "b2b.wr1");
    access(1'b0, 1'b0, 8'h60, 8'h00, 8'h5B, "b2b.rd0");
    access(1'b0, 1'b0, 8'h61, 8'h00, 8'hC3, "b2b.rd1");
    check("b2b.ack_count", 32'(core_acks - acks0), 32'(4));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the processor core and the host loader. The core issues LDAC/STACI accesses; the host preloads matrix operands and reads back results. The block grants one access at a time. It sequences the memory enable, write and address signals and returns read data with a one-cycle ack pulse. The core has priority, but a host starvation limit bounds how long the host waits, and the host gets full priority once the core has halted (end_op).

Parameters:
DATA_W, 8, data memory word width
ADDR_W, 8, data memory address width
MEM_RD_LAT, 1, data memory read latency in cycles (≥1)
HOST_MAX_WAIT, 4, number of core grants allowed while the host waits before the host wins

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
core_req  in  1  core access request, held high until core_ack
core_we  in  1  1=write, 0=read; held with core_req
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  read data, valid while core_ack=1
core_ack  out  1  one-cycle completion pulse
core_halted  in  1  end_op from control_unit
host_req  in  1  host request (same rules as core_req)
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  read data, valid while host_ack=1
host_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
owner  out  2  00 none, 01 core, 10 host

Behaviour:
- All outputs are registered.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, core_ack=0, host_ack=0, core_rdata=0, host_rdata=0, owner=00. Internally, state=IDLE and starve_cnt=0.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - With no request, stay in IDLE with owner=00.
  - With any request, latch the winner's we/addr/wdata, set owner, and go to ISSUE.
- Winner selection:
  - Only one requester high: that requester wins.
  - Both high: host wins if core_halted=1 or starve_cnt==HOST_MAX_WAIT; otherwise core wins.
- ISSUE: mem_en=1 for exactly this one cycle; mem_we=latched we.
  - Write: go to DONE.
  - Read: go to WAIT_RD and load the latency counter with MEM_RD_LAT-1.
- WAIT_RD:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register and go to DONE.
  - For MEM_RD_LAT=1, this is one cycle after ISSUE.
- DONE: the owner's ack=1 for one cycle, then go to IDLE. Requests are not sampled in DONE.
- Requester contract: drop req at the edge that ends the ack cycle. Requests must not be re-raised earlier.
- Request-to-ack latency, counting the req-sampling edge as cycle 0: write ack in cycle 2; read ack in cycle 2+MEM_RD_LAT.
- starve_cnt:
  - Increments (saturating at HOST_MAX_WAIT) on each core grant made while host_req=1.
  - Clears on each host grant.
- Between ISSUE cycles, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- The non-owner's ack is never asserted. rdata registers hold their value after ack.
- Requests arriving during ISSUE, WAIT_RD or DONE are serviced only after the return to IDLE. Request changes during a grant do not affect the latched access.
- rst_n asserted mid-access: everything returns immediately to the reset values. The access is abandoned with no ack, and mem_we never extends past reset.
- Illegal state encoding: recover to IDLE with outputs at their reset values.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding: IDLE/ISSUE/WAIT_RD/DONE
  - owner codes: OWN_NONE/OWN_CORE/OWN_HOST
  - default widths
- Sub-module dmem_grant_sel: combinational winner pick from core_req, host_req, core_halted and starve_cnt==HOST_MAX_WAIT. It outputs grant_core and grant_host, one-hot or zero.

Test Plan:
- Core write only: core_req=1, we=1, addr=0x10, wdata=0xA5 → mem_en=mem_we=1 with addr 0x10 for one cycle; core_ack in cycle 2; host_ack stays 0.
- Host read: host addr=0x20, memory returns 0x3C, MEM_RD_LAT=1 → host_rdata=0x3C and host_ack in cycle 3; owner=10 until DONE ends.
- Contention: both request continuously with core_halted=0 and HOST_MAX_WAIT=4 → grant order core×4 then host; starve_cnt returns to 0 after the host grant.
- Halted priority: core_halted=1 with both requesting → host is granted first.
- Reset mid-read: rst_n falls during WAIT_RD → no ack, all outputs 0, owner=00; the next request after release completes normally.
- Back-to-back: core holds req through DONE, then drops and re-raises it → exactly one ack per request, and there is no grant in DONE.
